dvfs_transition_sequencer: RTL and testbench

Sequences DVFS operating-point changes between a policy requester and the clock divider / voltage regulator. It enforces safe ordering: on a speed-up, voltage is raised before frequency; on a slow-down, frequency is lowered before voltage. It inserts a PLL/divider settle window and guards the regulator handshake with a timeout. It sits between the DVFS policy controller and the dynamic frequency divider / VREG interface.

---
 rtl/dvfs_transition_sequencer_if.sv | 64 ++++++
 rtl/dvfs_transition_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_dvfs_transition_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dvfs_transition_sequencer_if.sv
// Handshake bundle between the DVFS policy controller / voltage regulator side and the
// DVFS transition sequencer.
//
// Signals:
//   req_valid, req_level   policy -> sequencer: new operating level request
//   req_ready              sequencer -> policy: request can be accepted this cycle
//   cur_level              committed operating level
//   freq_div, freq_upd     divider ratio and its one-cycle update strobe
//   vreg_req, vreg_level   regulator request and target voltage code
//   vreg_ack               regulator -> sequencer: single-cycle done pulse
//   busy                   transition in progress
//   err_timeout, err_clr   sticky regulator-timeout flag and its clear
//
// Modports: master = policy/regulator side, slave = sequencer.
// NUM_LEVELS must match the sequencer instance it is connected to.
interface dvfs_transition_sequencer_if #(
    parameter int unsigned NUM_LEVELS = 4
);
    localparam int unsigned LevelW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int unsigned DivW   = NUM_LEVELS;

    logic              req_valid;
    logic [LevelW-1:0] req_level;
    logic              req_ready;
    logic [LevelW-1:0] cur_level;
    logic [DivW-1:0]   freq_div;
    logic              freq_upd;
    logic              vreg_req;
    logic [LevelW-1:0] vreg_level;
    logic              vreg_ack;
    logic              busy;
    logic              err_timeout;
    logic              err_clr;

    modport master (
        output req_valid,
        output req_level,
        output vreg_ack,
        output err_clr,
        input  req_ready,
        input  cur_level,
        input  freq_div,
        input  freq_upd,
        input  vreg_req,
        input  vreg_level,
        input  busy,
        input  err_timeout
    );

    modport slave (
        input  req_valid,
        input  req_level,
        input  vreg_ack,
        input  err_clr,
        output req_ready,
        output cur_level,
        output freq_div,
        output freq_upd,
        output vreg_req,
        output vreg_level,
        output busy,
        output err_timeout
    );
endinterface

// File: rtl/dvfs_transition_sequencer.sv
// DVFS transition sequencer.
//
// Orders operating-point changes so the core never runs faster than its supply allows:
// speed-ups raise the voltage first and then the frequency, slow-downs lower the frequency
// first and then the voltage. Every divider update is followed by a settle window, and every
// regulator handshake is bounded by a timeout that sets a sticky error flag.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    dvfs_transition_sequencer_if.slave (request, divider, regulator, status signals)
module dvfs_transition_sequencer #(
    parameter int unsigned NUM_LEVELS    = 4,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned VREG_TIMEOUT  = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    dvfs_transition_sequencer_if.slave     bus
);
    localparam int unsigned LevelW  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int unsigned DivW    = NUM_LEVELS;
    localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned ToW     = $clog2(VREG_TIMEOUT + 1);

    localparam logic [LevelW-1:0]  ResetLevel = LevelW'(1);
    localparam logic [LevelW-1:0]  MaxLevel   = LevelW'(NUM_LEVELS - 1);
    // Divider ratio of the reset level (level 1).
    localparam logic [DivW-1:0]    ResetDiv   = DivW'(1) << (NUM_LEVELS - 2);
    localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYCLES);
    localparam logic [ToW-1:0]     ToTerm     = ToW'(VREG_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StVUp,
        StFSet,
        StSettle,
        StVDn
    } state_e;

    state_e              state_q, state_d;
    logic [LevelW-1:0]   tgt_q, tgt_d;
    logic                up_q, up_d;
    logic [LevelW-1:0]   cur_q, cur_d;
    logic [DivW-1:0]     div_q, div_d;
    logic [LevelW-1:0]   vlev_q, vlev_d;
    logic [SettleW-1:0]  settle_q, settle_d;
    logic [ToW-1:0]      to_q, to_d;
    logic                err_q, err_d;

    logic [LevelW-1:0]   req_tgt;
    logic [ToW-1:0]      to_inc;
    logic                to_expire;
    logic                timeout_hit;

    function automatic logic [DivW-1:0] level_to_div(input logic [LevelW-1:0] lvl);
        return DivW'(1) << (MaxLevel - lvl);
    endfunction

    // Out-of-range levels only exist when NUM_LEVELS is not a power of two.
    assign req_tgt = (32'(bus.req_level) >= NUM_LEVELS) ? MaxLevel : bus.req_level;

    // Saturating timeout count; expiry is the cycle the count would reach VREG_TIMEOUT.
    assign to_inc    = (to_q == ToTerm) ? to_q : to_q + ToW'(1);
    assign to_expire = (to_inc == ToTerm);

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        up_d        = up_q;
        cur_d       = cur_q;
        div_d       = div_q;
        vlev_d      = vlev_q;
        settle_d    = settle_q;
        to_d        = to_q;
        err_d       = err_q;
        timeout_hit = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    tgt_d = req_tgt;
                    if (req_tgt > cur_q) begin
                        up_d    = 1'b1;
                        vlev_d  = req_tgt;
                        to_d    = '0;
                        state_d = StVUp;
                    end else if (req_tgt < cur_q) begin
                        up_d    = 1'b0;
                        // New ratio is registered on entry so it is valid while freq_upd is high.
                        div_d   = level_to_div(req_tgt);
                        state_d = StFSet;
                    end
                end
            end

            StVUp: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (bus.vreg_ack) begin
                    div_d   = level_to_div(tgt_q);
                    state_d = StFSet;
                end else if (to_expire) begin
                    timeout_hit = 1'b1;
                    vlev_d      = cur_q;
                    to_d        = to_inc;
                    state_d     = StIdle;
                end else begin
                    to_d = to_inc;
                end
            end

            StFSet: begin
                settle_d = SettleLoad;
                state_d  = StSettle;
            end

            StSettle: begin
                if (settle_q <= SettleW'(1)) begin
                    settle_d = '0;
                    if (up_q) begin
                        cur_d   = tgt_q;
                        state_d = StIdle;
                    end else begin
                        vlev_d  = tgt_q;
                        to_d    = '0;
                        state_d = StVDn;
                    end
                end else begin
                    settle_d = settle_q - SettleW'(1);
                end
            end

            StVDn: begin
                if (bus.vreg_ack) begin
                    cur_d   = tgt_q;
                    state_d = StIdle;
                end else if (to_expire) begin
                    // Frequency is already low, so committing the level is safe; the supply
                    // code falls back to the level the regulator was last known to hold.
                    timeout_hit = 1'b1;
                    cur_d       = tgt_q;
                    vlev_d      = cur_q;
                    to_d        = to_inc;
                    state_d     = StIdle;
                end else begin
                    to_d = to_inc;
                end
            end

            default: state_d = StIdle;
        endcase

        // Set has priority over a simultaneous clear.
        if (bus.err_clr) begin
            err_d = 1'b0;
        end
        if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            tgt_q    <= ResetLevel;
            up_q     <= 1'b0;
            cur_q    <= ResetLevel;
            div_q    <= ResetDiv;
            vlev_q   <= ResetLevel;
            settle_q <= '0;
            to_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            up_q     <= up_d;
            cur_q    <= cur_d;
            div_q    <= div_d;
            vlev_q   <= vlev_d;
            settle_q <= settle_d;
            to_q     <= to_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready   = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.vreg_req    = (state_q == StVUp) || (state_q == StVDn);
    assign bus.freq_upd    = (state_q == StFSet);
    assign bus.cur_level   = cur_q;
    assign bus.freq_div    = div_q;
    assign bus.vreg_level  = vlev_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// Self-checking bench for dvfs_transition_sequencer: a table of transactions with
// hand-computed results and timing, plus directed reset and stray-ack sequences.
module tb_dvfs_transition_sequencer;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    dvfs_transition_sequencer_if #(.NUM_LEVELS(4)) bus ();

    dvfs_transition_sequencer #(
        .NUM_LEVELS   (4),
        .SETTLE_CYCLES(64),
        .VREG_TIMEOUT (1024)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int lvl;        // requested level
        int d;          // ack delay after vreg_req rises, -1 = never ack
        int clr_hold;   // hold err_clr high for the whole transaction
        int clr_after;  // pulse err_clr after the transaction and expect the flag cleared
        int exp_cur;
        int exp_div;
        int exp_vlev;
        int exp_err;
        int exp_nupd;   // number of freq_upd pulses
        int exp_rise;   // 1 if vreg_req is expected to rise
        int exp_gap;    // freq_upd cycle minus vreg_req rise cycle
        int exp_lat;    // request-drive cycle to first idle cycle
    } txn_t;

    txn_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_cur_level"}, int'(bus.cur_level), 1);
        chk({pfx, "_freq_div"}, int'(bus.freq_div), 4);
        chk({pfx, "_vreg_level"}, int'(bus.vreg_level), 1);
        chk({pfx, "_vreg_req"}, int'(bus.vreg_req), 0);
        chk({pfx, "_freq_upd"}, int'(bus.freq_upd), 0);
        chk({pfx, "_busy"}, int'(bus.busy), 0);
        chk({pfx, "_err_timeout"}, int'(bus.err_timeout), 0);
        chk({pfx, "_req_ready"}, int'(bus.req_ready), 1);
    endtask

    // Called at a negedge with the DUT idle. Cycle 0 is the drive cycle.
    task automatic run_txn(input int lvl, input int d, input int clr_hold,
                           output int lat, output int rise_n, output int upd_n,
                           output int nupd, output int vlev_rise, output int unstable,
                           output int div_upd);
        int n;
        lat = -1; rise_n = -1; upd_n = -1; nupd = 0;
        vlev_rise = -1; unstable = 0; div_upd = -1;
        n = 0;
        bus.req_level = 2'(lvl);
        bus.req_valid = 1'b1;
        bus.err_clr   = (clr_hold != 0);
        while (lat < 0 && n < 3000) begin
            @(negedge clk);
            n++;
            bus.req_valid = 1'b0;
            if (bus.vreg_req) begin
                if (rise_n < 0) begin
                    rise_n    = n;
                    vlev_rise = int'(bus.vreg_level);
                end else if (int'(bus.vreg_level) != vlev_rise) begin
                    unstable = 1;
                end
            end
            if (bus.freq_upd) begin
                nupd++;
                upd_n   = n;
                div_upd = int'(bus.freq_div);
            end
            bus.vreg_ack = (rise_n >= 0 && d >= 0 && n == rise_n + d);
            if (!bus.busy) begin
                lat = n;
                bus.vreg_ack = 1'b0;
            end
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL txn_budget: got busy after %0d cycles expected idle", n);
        end
        bus.vreg_ack = 1'b0;
        bus.err_clr  = 1'b0;
    endtask

    initial begin
        int lat, rise_n, upd_n, nupd, vlev_rise, unstable, div_upd;
        bit seen;
        total = 0;
        bad   = 0;
        bus.req_valid = 1'b0;
        bus.req_level = '0;
        bus.vreg_ack  = 1'b0;
        bus.err_clr   = 1'b0;
        rst_n = 1'b0;

        //          lvl  d    hold aft cur div vlev err nupd rise gap   lat
        tbl[0] = '{3,   5,    0,   0,  3,  1,  3,   0,  1,   1,   6,    72};
        tbl[1] = '{0,   3,    0,   0,  0,  8,  0,   0,  1,   1,   -65,  70};
        tbl[2] = '{0,   -1,   0,   0,  0,  8,  0,   0,  0,   0,   0,    1};
        tbl[3] = '{2,   -1,   0,   0,  0,  8,  0,   1,  0,   1,   0,    1025};
        tbl[4] = '{2,   1023, 0,   1,  2,  2,  2,   1,  1,   1,   1024, 1090};
        tbl[5] = '{1,   -1,   1,   0,  1,  4,  2,   1,  1,   1,   -65,  1090};
        tbl[6] = '{3,   0,    0,   0,  3,  1,  3,   1,  1,   1,   1,    67};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");

        // Stray ack while idle must be ignored.
        bus.vreg_ack = 1'b1;
        @(negedge clk);
        bus.vreg_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_busy", int'(bus.busy), 0);
        chk("stray_ack_vreg_req", int'(bus.vreg_req), 0);
        chk("stray_ack_cur_level", int'(bus.cur_level), 1);

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].lvl, tbl[i].d, tbl[i].clr_hold,
                    lat, rise_n, upd_n, nupd, vlev_rise, unstable, div_upd);
            chk($sformatf("row%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("row%0d_cur_level", i), int'(bus.cur_level), tbl[i].exp_cur);
            chk($sformatf("row%0d_freq_div", i), int'(bus.freq_div), tbl[i].exp_div);
            chk($sformatf("row%0d_vreg_level", i), int'(bus.vreg_level), tbl[i].exp_vlev);
            chk($sformatf("row%0d_err_timeout", i), int'(bus.err_timeout), tbl[i].exp_err);
            chk($sformatf("row%0d_upd_pulses", i), nupd, tbl[i].exp_nupd);
            chk($sformatf("row%0d_vreg_rose", i), int'(rise_n >= 0), tbl[i].exp_rise);
            chk($sformatf("row%0d_req_ready", i), int'(bus.req_ready), 1);
            if (tbl[i].exp_nupd > 0) begin
                chk($sformatf("row%0d_div_at_upd", i), div_upd, tbl[i].exp_div);
            end
            if (tbl[i].exp_rise > 0) begin
                chk($sformatf("row%0d_vlev_at_req", i), vlev_rise, tbl[i].lvl);
                chk($sformatf("row%0d_vlev_stable", i), unstable, 0);
            end
            if (tbl[i].exp_rise > 0 && tbl[i].exp_nupd > 0) begin
                chk($sformatf("row%0d_upd_minus_req", i), upd_n - rise_n, tbl[i].exp_gap);
            end
            if (tbl[i].clr_after > 0) begin
                bus.err_clr = 1'b1;
                @(negedge clk);
                bus.err_clr = 1'b0;
                chk($sformatf("row%0d_err_cleared", i), int'(bus.err_timeout), 0);
            end
        end

        // Reset in the middle of the settle window of a 1 -> 3 transition.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.req_level = 2'd3;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            seen = bus.freq_upd;
            bus.vreg_ack = bus.vreg_req;
            if (!seen) @(negedge clk);
        end
        bus.vreg_ack = 1'b0;
        chk("mid_rst_upd_seen", int'(seen), 1);
        repeat (10) @(negedge clk);
        chk("mid_rst_busy_before", int'(bus.busy), 1);
        chk("mid_rst_div_before", int'(bus.freq_div), 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(3, 5, 0, lat, rise_n, upd_n, nupd, vlev_rise, unstable, div_upd);
        chk("post_rst_latency", lat, 72);
        chk("post_rst_cur_level", int'(bus.cur_level), 3);
        chk("post_rst_freq_div", int'(bus.freq_div), 1);
        chk("post_rst_upd_pulses", nupd, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
